// File: rtl/shift_unit.sv
// Multi-cycle barrel-less shifter: one bit per clock, SRA or SLL, up to 31 steps.
// Result and completion pulse are registered; the unit takes no new work while busy.
module shift_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_shift,
  input  logic        sig_sra,
  input  logic        sig_sll,
  input  logic [31:0] data_operand,
  input  logic [4:0]  shamt,
  output logic [31:0] data_result,
  output logic        data_resultRDY,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e      state_q, state_d;
  logic [31:0] opr_q, opr_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        sra_q, sra_d;
  logic        rdy_q, rdy_d;
  logic        busy_q, busy_d;
  logic [31:0] step;

  assign step = sra_q ? {opr_q[31], opr_q[31:1]} : {opr_q[30:0], 1'b0};

  always_comb begin
    state_d = state_q;
    opr_d   = opr_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    sra_d   = sra_q;
    case (state_q)
      IDLE: begin
        if (ctrl_shift && (sig_sra || sig_sll)) begin
          opr_d = data_operand;
          sra_d = sig_sra;  // sra wins when both selects are high
          cnt_d = shamt;
          if (shamt == 5'd0) begin
            state_d = DONE;
            res_d   = data_operand;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        opr_d = step;
        cnt_d = cnt_q - 5'd1;
        // Leave on the last step so the count never wraps below zero
        if (cnt_q == 5'd1) begin
          state_d = DONE;
          res_d   = step;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    rdy_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      opr_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      sra_q   <= 1'b0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opr_q   <= opr_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      sra_q   <= sra_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
    end
  end

  assign data_result    = res_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: doc/shift_unit.md
SHIFT_UNIT -- requirements
Module: shift_unit

Interface
REQ-001 Parameters: none; data width fixed at 32 bits, shift amount fixed at 5 bits.
REQ-002 clock  input  1  Single clock domain; all state updates on its rising edge.
REQ-003 reset  input  1  Asynchronous, active-low; clears all state immediately when low.
REQ-004 ctrl_shift  input  1  Start request; sampled only on a rising clock edge while the unit is IDLE.
REQ-005 sig_sra  input  1  Arithmetic-right-shift select from the decode minterm stage; sampled with ctrl_shift.
REQ-006 sig_sll  input  1  Logical-left-shift select from the decode minterm stage; sampled with ctrl_shift.
REQ-007 data_operand  input  32  Value to shift; sampled with ctrl_shift.
REQ-008 shamt  input  5  Shift amount, 0..31; sampled with ctrl_shift.
REQ-009 data_result  output  32  Shifted value; holds its value between operations.
REQ-010 data_resultRDY  output  1  One-cycle completion pulse; data_result is valid while this is high.
REQ-011 busy  output  1  High in SHIFT and DONE; low in IDLE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-013 IDLE, edge with ctrl_shift=1 and (sig_sra or sig_sll)=1: load operand register, latch op, load count=shamt; go to SHIFT if shamt!=0, else DONE.
REQ-014 IDLE, edge with ctrl_shift=1 and sig_sra=sig_sll=0: SHALL be ignored; remain IDLE with no RDY pulse.
REQ-015 If sig_sra and sig_sll are both high at start, sra SHALL take priority.
REQ-016 SHIFT, each edge: shift the operand register by exactly 1 bit and decrement count; when count reaches 0, go to DONE.
REQ-017 sra step: shift right by one and replicate bit 31; sll step: shift left by one and insert 0 at bit 0.
REQ-018 DONE: data_resultRDY=1 and data_result=operand register for exactly one cycle; next edge go to IDLE.
REQ-019 Latency: with start sampled at edge E0, data_resultRDY SHALL be high in clock cycle shamt+1 (shamt=0 gives cycle 1; shamt=31 gives cycle 32).
REQ-020 ctrl_shift, sig_*, data_operand and shamt SHALL be ignored while busy=1; no queuing.
REQ-021 A start in the IDLE cycle immediately following DONE SHALL be accepted (back-to-back issue, one idle cycle minimum).
REQ-022 data_result SHALL update only on entry to DONE and hold until the next DONE.
REQ-023 The result SHALL equal the single-step shift applied shamt times, with no wrap-around of the count past 0.

Reset
REQ-024 When reset=0, state=IDLE, data_result=0, data_resultRDY=0, busy=0, count=0, and the operand register=0, asynchronously.
REQ-025 If reset is asserted mid-operation, the operation SHALL be discarded with no RDY pulse; after release the unit accepts a new start on the first edge.
REQ-026 Outputs SHALL be driven from registers only; no combinational path from inputs to outputs.

Verification
REQ-027 sra, data_operand=0x80000010, shamt=4 -> RDY in cycle 5, data_result=0xF8000001, busy high in cycles 1-5.
REQ-028 sll, data_operand=0x00000003, shamt=31 -> RDY in cycle 32, data_result=0x80000000; a second start in cycle 10 is ignored.
REQ-029 sra, shamt=0, data_operand=0xDEADBEEF -> RDY in cycle 1, data_result=0xDEADBEEF.
REQ-030 sig_sra=sig_sll=1, data_operand=0xF0000000, shamt=1 -> data_result=0xF8000000 (sra priority); start with both low -> no RDY, busy stays 0.
REQ-031 Start sll with shamt=8, assert reset in cycle 3 -> all outputs 0 immediately; no RDY follows; a new start after release completes normally.
REQ-032 Back-to-back: sll with shamt=1, then a start in the first IDLE cycle after DONE -> both accepted, two RDY pulses each with the correct result.
